// File: rtl/wb_regfile.sv
// Writeback stage: builds the final W value, commits it to the 32x32
// register file, serves two bypassed D-stage read ports and counts retirements.
module wb_regfile (
   input  logic        clk,
   input  logic        clr,
   input  logic [2:0]  res_w,
   input  logic [31:0] instr_w,
   input  logic [4:0]  a3_w,
   input  logic [31:0] ao_w,
   input  logic [31:0] dr_w,
   input  logic [31:0] pc8_w,
   input  logic [4:0]  a1_d,
   input  logic [4:0]  a2_d,
   output logic [31:0] rd1_d,
   output logic [31:0] rd2_d,
   output logic [31:0] wd_w,
   output logic        we_w,
   output logic [31:0] retired
);

   localparam logic [2:0] RES_ALU = 3'd1;
   localparam logic [2:0] RES_DM  = 3'd2;
   localparam logic [2:0] RES_PC8 = 3'd3;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;

   logic [31:0] regs_q [1:31];
   logic [31:0] retired_q;
   logic [31:0] retired_d;
   logic [31:0] load_val;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [5:0]  opcode;

   assign opcode = instr_w[31:26];

   always_comb begin
      byte_sel = dr_w[7:0];
      case (ao_w[1:0])
         2'd0: byte_sel = dr_w[7:0];
         2'd1: byte_sel = dr_w[15:8];
         2'd2: byte_sel = dr_w[23:16];
         2'd3: byte_sel = dr_w[31:24];
         default: byte_sel = dr_w[7:0];
      endcase
   end

   // Halfword select ignores ao_w[0]: unaligned halves are not supported.
   assign half_sel = ao_w[1] ? dr_w[31:16] : dr_w[15:0];

   always_comb begin
      load_val = dr_w;
      case (opcode)
         OP_LW:   load_val = dr_w;
         OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_val = {24'h0, byte_sel};
         OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_val = {16'h0, half_sel};
         default: load_val = dr_w;
      endcase
   end

   always_comb begin
      wd_w = 32'h0;
      case (res_w)
         RES_ALU: wd_w = ao_w;
         RES_DM:  wd_w = load_val;
         RES_PC8: wd_w = pc8_w;
         default: wd_w = 32'h0;
      endcase
   end

   assign we_w = (res_w == RES_ALU || res_w == RES_DM || res_w == RES_PC8)
              && (a3_w != 5'd0);

   always_comb begin
      rd1_d = 32'h0;
      if (a1_d == 5'd0)
         rd1_d = 32'h0;
      else if (we_w && a1_d == a3_w)
         rd1_d = wd_w;
      else
         rd1_d = regs_q[a1_d];
   end

   always_comb begin
      rd2_d = 32'h0;
      if (a2_d == 5'd0)
         rd2_d = 32'h0;
      else if (we_w && a2_d == a3_w)
         rd2_d = wd_w;
      else
         rd2_d = regs_q[a2_d];
   end

   assign retired_d = retired_q + {31'h0, (instr_w != 32'h0)};

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 1; i < 32; i++)
            regs_q[i] <= 32'h0;
         retired_q <= 32'h0;
      end else begin
         if (we_w)
            regs_q[a3_w] <= wd_w;
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: writeback select, load
// extension, bypass, $0 protection, reset and retire counter.
module tb_wb_regfile;

   logic        clk;
   logic        clr;
   logic [2:0]  res_w;
   logic [31:0] instr_w;
   logic [4:0]  a3_w;
   logic [31:0] ao_w;
   logic [31:0] dr_w;
   logic [31:0] pc8_w;
   logic [4:0]  a1_d;
   logic [4:0]  a2_d;
   logic [31:0] rd1_d;
   logic [31:0] rd2_d;
   logic [31:0] wd_w;
   logic        we_w;
   logic [31:0] retired;

   int n_run;
   int n_fail;

   localparam logic [31:0] I_ADD = 32'h0000_0020;
   localparam logic [31:0] I_LB  = {6'b100000, 26'h1};
   localparam logic [31:0] I_LH  = {6'b100001, 26'h1};
   localparam logic [31:0] I_LW  = {6'b100011, 26'h1};
   localparam logic [31:0] I_LBU = {6'b100100, 26'h1};
   localparam logic [31:0] I_LHU = {6'b100101, 26'h1};
   localparam logic [31:0] I_OTH = {6'b101011, 26'h1};

   wb_regfile dut (
      .clk     (clk),
      .clr     (clr),
      .res_w   (res_w),
      .instr_w (instr_w),
      .a3_w    (a3_w),
      .ao_w    (ao_w),
      .dr_w    (dr_w),
      .pc8_w   (pc8_w),
      .a1_d    (a1_d),
      .a2_d    (a2_d),
      .rd1_d   (rd1_d),
      .rd2_d   (rd2_d),
      .wd_w    (wd_w),
      .we_w    (we_w),
      .retired (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic idle();
      res_w = 3'd0; instr_w = 32'h0; a3_w = 5'd0;
      ao_w = 32'h0; dr_w = 32'h0; pc8_w = 32'h0;
   endtask

   // Drive a W bundle at the negedge, so it commits on the next posedge.
   task automatic drive(input logic [2:0] r, input logic [31:0] ins,
                        input logic [4:0] a3, input logic [31:0] ao,
                        input logic [31:0] dr, input logic [31:0] pc8);
      @(negedge clk);
      res_w = r; instr_w = ins; a3_w = a3;
      ao_w = ao; dr_w = dr; pc8_w = pc8;
      #1;
   endtask

   task automatic load(input string tag, input logic [31:0] ins,
                       input logic [1:0] off, input logic [31:0] exp);
      drive(3'd2, ins, 5'd9, {30'h1000, off}, 32'h80FF7F01, 32'h0);
      check(tag, wd_w, exp);
   endtask

   initial begin
      n_run = 0;
      n_fail = 0;
      clr = 1'b1;
      a1_d = 5'd0;
      a2_d = 5'd0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      a1_d = 5'd5;
      #1;
      check("rst_retired", retired, 32'h0);
      check("rst_reg5", rd1_d, 32'h0);

      @(negedge clk);
      clr = 1'b0;
      drive(3'd1, I_ADD, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0);
      drive(3'd1, I_ADD, 5'd31, 32'hDEADBEEF, 32'h0, 32'h0);
      @(negedge clk);
      idle();
      a1_d = 5'd5; a2_d = 5'd31;
      #1;
      check("pre_clr_r5", rd1_d, 32'hDEADBEEF);
      check("pre_clr_r31", rd2_d, 32'hDEADBEEF);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      #1;
      check("clr_r5", rd1_d, 32'h0);
      check("clr_r31", rd2_d, 32'h0);
      check("clr_retired", retired, 32'h0);

      a1_d = 5'd0;
      drive(3'd1, I_ADD, 5'd0, 32'h1234, 32'h0, 32'h0);
      check("r0_we", {31'h0, we_w}, 32'h0);
      check("r0_rd", rd1_d, 32'h0);

      a1_d = 5'd8;
      drive(3'd1, I_ADD, 5'd8, 32'h55, 32'h0, 32'h0);
      check("alu_we", {31'h0, we_w}, 32'h1);
      check("alu_bypass", rd1_d, 32'h55);
      @(negedge clk);
      idle();
      #1;
      check("alu_array", rd1_d, 32'h55);

      drive(3'd3, I_ADD, 5'd31, 32'h0, 32'h0, 32'h3008);
      check("pc8_wd", wd_w, 32'h3008);
      @(negedge clk);
      idle();
      a2_d = 5'd31;
      #1;
      check("pc8_array", rd2_d, 32'h3008);

      load("lb_off3", I_LB, 2'd3, 32'hFFFFFF80);
      load("lbu_off3", I_LBU, 2'd3, 32'h00000080);
      load("lb_off1", I_LB, 2'd1, 32'h0000007F);
      load("lbu_off0", I_LBU, 2'd0, 32'h00000001);
      load("lb_off2", I_LB, 2'd2, 32'hFFFFFFFF);
      load("lh_off2", I_LH, 2'd2, 32'hFFFF80FF);
      load("lh_off3", I_LH, 2'd3, 32'hFFFF80FF);
      load("lhu_off0", I_LHU, 2'd0, 32'h00007F01);
      load("lhu_off1", I_LHU, 2'd1, 32'h00007F01);
      load("lw", I_LW, 2'd0, 32'h80FF7F01);
      load("other_op", I_OTH, 2'd3, 32'h80FF7F01);
      @(negedge clk);
      idle();
      a1_d = 5'd9;
      #1;
      check("load_array", rd1_d, 32'h80FF7F01);

      drive(3'd5, I_ADD, 5'd10, 32'h99, 32'h0, 32'h0);
      check("res5_wd", wd_w, 32'h0);
      check("res5_we", {31'h0, we_w}, 32'h0);

      drive(3'd1, I_ADD, 5'd3, 32'h11, 32'h0, 32'h0);
      drive(3'd1, I_ADD, 5'd4, 32'h22, 32'h0, 32'h0);
      @(negedge clk);
      idle();
      a1_d = 5'd3; a2_d = 5'd4;
      #1;
      check("dual_p1", rd1_d, 32'h11);
      check("dual_p2", rd2_d, 32'h22);
      a1_d = 5'd4;
      drive(3'd1, I_ADD, 5'd4, 32'h33, 32'h0, 32'h0);
      check("same_p1", rd1_d, 32'h33);
      check("same_p2", rd2_d, 32'h33);

      a1_d = 5'd7;
      drive(3'd1, I_ADD, 5'd7, 32'h1, 32'h0, 32'h0);
      drive(3'd1, I_ADD, 5'd7, 32'h2, 32'h0, 32'h0);
      check("b2b_bypass", rd1_d, 32'h2);
      @(negedge clk);
      idle();
      #1;
      check("b2b_array", rd1_d, 32'h2);

      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      drive(3'd0, 32'h1, 5'd0, 32'h0, 32'h0, 32'h0);
      drive(3'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0);
      drive(3'd0, 32'h2, 5'd0, 32'h0, 32'h0, 32'h0);
      drive(3'd0, 32'h3, 5'd0, 32'h0, 32'h0, 32'h0);
      drive(3'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0);
      drive(3'd0, 32'h4, 5'd0, 32'h0, 32'h0, 32'h0);
      drive(3'd0, 32'h5, 5'd0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      idle();
      #1;
      check("retire_5", retired, 32'd5);

      force dut.retired_q = 32'hFFFFFFFF;
      #1;
      release dut.retired_q;
      #1;
      check("retire_max", retired, 32'hFFFFFFFF);
      instr_w = 32'h7;
      @(negedge clk);
      idle();
      #1;
      check("retire_wrap", retired, 32'h0);

      a1_d = 5'd6;
      drive(3'd1, I_ADD, 5'd6, 32'h77, 32'h0, 32'h0);
      @(negedge clk);
      res_w = 3'd1; instr_w = I_ADD; a3_w = 5'd6; ao_w = 32'hAA;
      clr = 1'b1;
      #1;
      check("clr_bypass", rd1_d, 32'hAA);
      @(negedge clk);
      clr = 1'b0;
      idle();
      #1;
      check("clr_wr_r6", rd1_d, 32'h0);
      check("clr_wr_ret", retired, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
